// File: rtl/inc_arbiter.sv
// Shared 16-bit incrementer arbitrated between two requesters A and B.
// Latency: one cycle from request sampled at a rising edge to registered grant/result.
// Backpressure: none; a requester holds req until it sees its one-cycle grant.
//
// Ports:
//   clk, rst_n          sole clock, asynchronous active-low reset
//   req_a/in_a          requester A: wants one increment of in_a
//   req_b/in_b          requester B: wants one increment of in_b
//   gnt_a/gnt_b         registered one-cycle grant/acknowledge
//   valid               out/ovf carry a fresh result this cycle
//   out/ovf             granted operand + 1 (mod 2^16) and its carry out
//   owner               0 = result belongs to A, 1 = to B
module inc_arbiter #(
    parameter int FAIR = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_a,
    input  logic [15:0] in_a,
    input  logic        req_b,
    input  logic [15:0] in_b,
    output logic        gnt_a,
    output logic        gnt_b,
    output logic        valid,
    output logic [15:0] out,
    output logic        ovf,
    output logic        owner
);

    // One bit per serve state so the grants decode straight from flops.
    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        SERVE_A = 2'b01,
        SERVE_B = 2'b10
    } state_t;

    state_t      state;
    state_t      next_state;
    logic        last_b;      // 1 = B was served most recently
    logic        sel_b;       // operand mux select for the granting edge
    logic [15:0] operand;
    logic [15:0] sum;
    logic [16:0] carry;

    // ------------------------------------------------------------------
    // State register, last-served pointer and result capture
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            last_b <= 1'b1;   // "B last" so A wins the first tie
            out    <= 16'h0000;
            ovf    <= 1'b0;
            owner  <= 1'b0;
        end else begin
            state <= next_state;
            // Pointer and result move only on a grant; IDLE holds them.
            if (next_state != IDLE) begin
                last_b <= sel_b;
                out    <= sum;
                ovf    <= carry[16];
                owner  <= sel_b;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        next_state = IDLE;
        if (req_a && req_b) begin
            if (FAIR != 0) begin
                next_state = last_b ? SERVE_A : SERVE_B;
            end else begin
                next_state = SERVE_A;
            end
        end else if (req_a) begin
            next_state = SERVE_A;
        end else if (req_b) begin
            next_state = SERVE_B;
        end
    end

    // ------------------------------------------------------------------
    // Output decode: grants/valid follow the registered state
    // ------------------------------------------------------------------
    always_comb begin
        gnt_a = 1'b0;
        gnt_b = 1'b0;
        valid = 1'b0;
        case (state)
            SERVE_A: begin
                gnt_a = 1'b1;
                valid = 1'b1;
            end
            SERVE_B: begin
                gnt_b = 1'b1;
                valid = 1'b1;
            end
            default: begin
                gnt_a = 1'b0;
                gnt_b = 1'b0;
                valid = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Single shared +1 datapath: operand chosen by the winner of this
    // edge, then a ripple of half adders with carry-in tied to 1.
    // ------------------------------------------------------------------
    assign sel_b   = (next_state == SERVE_B);
    assign operand = sel_b ? in_b : in_a;
    assign carry[0] = 1'b1;

    genvar i;
    generate
        for (i = 0; i < 16; i++) begin : g_ha
            assign sum[i]     = operand[i] ^ carry[i];
            assign carry[i+1] = operand[i] & carry[i];
        end
    endgenerate

endmodule

// File: tb/tb_inc_arbiter.sv
// Bench for inc_arbiter: a FAIR=1 and a FAIR=0 instance share stimulus.
// Expected results are queued when inputs are driven, compared after the edge.
// Summary line reports total comparisons and failures.
module tb_inc_arbiter;

    typedef struct packed {
        logic        gnt_a;
        logic        gnt_b;
        logic        valid;
        logic [15:0] out;
        logic        ovf;
        logic        owner;
    } res_t;

    typedef struct {
        logic        ra;
        logic [15:0] ia;
        logic        rb;
        logic [15:0] ib;
        res_t        exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_a = 1'b0;
    logic [15:0] in_a = 16'h0000;
    logic        req_b = 1'b0;
    logic [15:0] in_b = 16'h0000;

    logic        f_gnt_a, f_gnt_b, f_valid, f_ovf, f_owner;
    logic [15:0] f_out;
    logic        p_gnt_a, p_gnt_b, p_valid, p_ovf, p_owner;
    logic [15:0] p_out;

    res_t obs_fair;
    res_t obs_prio;
    res_t sb[$];

    int total = 0;
    int bad   = 0;

    vec_t tbl[18];

    always #5 clk = ~clk;

    inc_arbiter #(.FAIR(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req_a (req_a),
        .in_a  (in_a),
        .req_b (req_b),
        .in_b  (in_b),
        .gnt_a (f_gnt_a),
        .gnt_b (f_gnt_b),
        .valid (f_valid),
        .out   (f_out),
        .ovf   (f_ovf),
        .owner (f_owner)
    );

    inc_arbiter #(.FAIR(0)) dut_prio (
        .clk   (clk),
        .rst_n (rst_n),
        .req_a (req_a),
        .in_a  (in_a),
        .req_b (req_b),
        .in_b  (in_b),
        .gnt_a (p_gnt_a),
        .gnt_b (p_gnt_b),
        .valid (p_valid),
        .out   (p_out),
        .ovf   (p_ovf),
        .owner (p_owner)
    );

    assign obs_fair = {f_gnt_a, f_gnt_b, f_valid, f_out, f_ovf, f_owner};
    assign obs_prio = {p_gnt_a, p_gnt_b, p_valid, p_out, p_ovf, p_owner};

    function automatic res_t mk(input logic ga, input logic gb, input logic v,
                                input logic [15:0] o, input logic f, input logic w);
        res_t r;
        r.gnt_a = ga;
        r.gnt_b = gb;
        r.valid = v;
        r.out   = o;
        r.ovf   = f;
        r.owner = w;
        return r;
    endfunction

    task automatic check(input string name, input res_t got, input res_t exp);
        total++;
        if (got !== exp || (got.gnt_a && got.gnt_b)) begin
            bad++;
            $display("FAIL %s: got gnt_a=%b gnt_b=%b valid=%b out=%h ovf=%b owner=%b, want gnt_a=%b gnt_b=%b valid=%b out=%h ovf=%b owner=%b",
                     name, got.gnt_a, got.gnt_b, got.valid, got.out, got.ovf, got.owner,
                     exp.gnt_a, exp.gnt_b, exp.valid, exp.out, exp.ovf, exp.owner);
        end
    endtask

    // Drive one cycle of inputs, queue the expectation, compare after the edge.
    task automatic apply(input string name, input logic ra, input logic [15:0] ia,
                         input logic rb, input logic [15:0] ib, input res_t exp,
                         input bit on_prio);
        res_t e;
        req_a = ra;
        in_a  = ia;
        req_b = rb;
        in_b  = ib;
        sb.push_back(exp);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s: scoreboard empty, got nothing to compare", name);
        end else begin
            e = sb.pop_front();
            check(name, on_prio ? obs_prio : obs_fair, e);
        end
    endtask

    initial begin
        // {req_a, in_a, req_b, in_b, expected result after the edge} for FAIR=1
        tbl[0]  = '{1'b1, 16'h0041, 1'b0, 16'h0000, mk(1, 0, 1, 16'h0042, 0, 0)};
        tbl[1]  = '{1'b0, 16'h0041, 1'b1, 16'hFFFF, mk(0, 1, 1, 16'h0000, 1, 1)};
        tbl[2]  = '{1'b0, 16'h0041, 1'b1, 16'h7FFF, mk(0, 1, 1, 16'h8000, 0, 1)};
        tbl[3]  = '{1'b1, 16'h0010, 1'b1, 16'h0020, mk(1, 0, 1, 16'h0011, 0, 0)};
        tbl[4]  = '{1'b1, 16'h0010, 1'b1, 16'h0020, mk(0, 1, 1, 16'h0021, 0, 1)};
        tbl[5]  = '{1'b1, 16'h0010, 1'b1, 16'h0020, mk(1, 0, 1, 16'h0011, 0, 0)};
        tbl[6]  = '{1'b1, 16'h0010, 1'b1, 16'h0020, mk(0, 1, 1, 16'h0021, 0, 1)};
        tbl[7]  = '{1'b1, 16'h1234, 1'b0, 16'h0020, mk(1, 0, 1, 16'h1235, 0, 0)};
        tbl[8]  = '{1'b0, 16'hBEEF, 1'b0, 16'h0020, mk(0, 0, 0, 16'h1235, 0, 0)};
        tbl[9]  = '{1'b0, 16'hFFFF, 1'b0, 16'hFFFF, mk(0, 0, 0, 16'h1235, 0, 0)};
        tbl[10] = '{1'b0, 16'h0000, 1'b0, 16'h1111, mk(0, 0, 0, 16'h1235, 0, 0)};
        tbl[11] = '{1'b0, 16'h5555, 1'b0, 16'h2222, mk(0, 0, 0, 16'h1235, 0, 0)};
        tbl[12] = '{1'b0, 16'hAAAA, 1'b0, 16'h3333, mk(0, 0, 0, 16'h1235, 0, 0)};
        tbl[13] = '{1'b1, 16'h0001, 1'b0, 16'h3333, mk(1, 0, 1, 16'h0002, 0, 0)};
        tbl[14] = '{1'b1, 16'h0002, 1'b0, 16'h3333, mk(1, 0, 1, 16'h0003, 0, 0)};
        tbl[15] = '{1'b0, 16'h0002, 1'b1, 16'h0005, mk(0, 1, 1, 16'h0006, 0, 1)};
        tbl[16] = '{1'b0, 16'h0002, 1'b0, 16'h0005, mk(0, 0, 0, 16'h0006, 0, 1)};
        tbl[17] = '{1'b1, 16'hFFFF, 1'b1, 16'h0000, mk(1, 0, 1, 16'h0000, 1, 0)};

        // Reset values, checked while reset is held
        #12;
        check("reset_fair", obs_fair, mk(0, 0, 0, 16'h0000, 0, 0));
        check("reset_prio", obs_prio, mk(0, 0, 0, 16'h0000, 0, 0));
        rst_n = 1'b1;

        // Main table on the round-robin instance
        for (int i = 0; i < 18; i++) begin
            apply($sformatf("vec%0d", i), tbl[i].ra, tbl[i].ia, tbl[i].rb, tbl[i].ib,
                  tbl[i].exp, 1'b0);
        end

        // Reset in the middle of an A grant clears outputs without a clock edge
        apply("pre_rst_grant", 1'b1, 16'h0041, 1'b0, 16'h0000,
              mk(1, 0, 1, 16'h0042, 0, 0), 1'b0);
        rst_n = 1'b0;
        #1;
        check("async_rst", obs_fair, mk(0, 0, 0, 16'h0000, 0, 0));
        req_a = 1'b0;
        req_b = 1'b1;
        in_b  = 16'h0009;
        #1;
        rst_n = 1'b1;
        #1;
        check("post_rst_no_edge", obs_fair, mk(0, 0, 0, 16'h0000, 0, 0));
        apply("first_grant_b", 1'b0, 16'h0000, 1'b1, 16'h0009,
              mk(0, 1, 1, 16'h000A, 0, 1), 1'b0);

        // Fixed priority: A wins every tie, B only once A drops
        for (int i = 0; i < 4; i++) begin
            apply($sformatf("prio_tie%0d", i), 1'b1, 16'h0010, 1'b1, 16'h0020,
                  mk(1, 0, 1, 16'h0011, 0, 0), 1'b1);
        end
        apply("prio_b_after_a", 1'b0, 16'h0010, 1'b1, 16'h0020,
              mk(0, 1, 1, 16'h0021, 0, 1), 1'b1);
        apply("prio_idle", 1'b0, 16'h0010, 1'b0, 16'h0020,
              mk(0, 0, 0, 16'h0021, 0, 1), 1'b1);

        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL sb_drain: %0d entries left, want 0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/inc_arbiter.md
INC_ARBITER -- requirements
Module: inc_arbiter

Interface
REQ-001 Parameter FAIR, default 1, 1 = round-robin between A and B, 0 = fixed priority to A.
REQ-002 Port clk, input, 1, sole clock; all state changes on rising edge.
REQ-003 Port rst_n, input, 1, asynchronous active-low reset.
REQ-004 Port req_a, input, 1, requester A wants one 16-bit increment.
REQ-005 Port in_a, input, 16, requester A operand, held stable while req_a high.
REQ-006 Port req_b, input, 1, requester B wants one 16-bit increment.
REQ-007 Port in_b, input, 16, requester B operand, held stable while req_b high.
REQ-008 Port gnt_a, output, 1, registered one-cycle grant/acknowledge to A.
REQ-009 Port gnt_b, output, 1, registered one-cycle grant/acknowledge to B.
REQ-010 Port valid, output, 1, out/ovf hold a fresh result this cycle.
REQ-011 Port out, output, 16, registered result (granted operand + 1, modulo 2^16).
REQ-012 Port ovf, output, 1, carry out of the increment (operand was 16'hFFFF).
REQ-013 Port owner, output, 1, 0 = current result belongs to A, 1 = to B.

Function
REQ-014 The block SHALL contain exactly one 16-bit +1 datapath (ripple of half adders, carry-in 1), shared by A and B.
REQ-015 FSM states IDLE, SERVE_A, SERVE_B; state is registered, next state computed from req_a, req_b, last-served pointer.
REQ-016 At each rising edge: no request -> IDLE; only one request -> serve that requester; both -> arbitration per REQ-017/018.
REQ-017 FAIR=1, both requesting: serve the requester not served most recently; pointer initialised to "B last" so A wins the first tie.
REQ-018 FAIR=0, both requesting: A always wins; B served only when req_a low.
REQ-019 Entering SERVE_x: gnt_x=1, other grant 0, valid=1, owner=x, out=in_x+1, ovf=carry, all captured at the same edge; latency one cycle from request sampled to result.
REQ-020 Grant and result are valid for exactly one cycle; a requester still asserting req in its grant cycle is treated as a new request at the next edge.
REQ-021 Throughput one increment per cycle; back-to-back service of the same requester allowed when the other is idle.
REQ-022 The last-served pointer SHALL update only on a grant, never in IDLE.
REQ-023 In IDLE: gnt_a=gnt_b=0, valid=0; out, ovf, owner hold their previous values.
REQ-024 gnt_a and gnt_b SHALL never be high in the same cycle.
REQ-025 Wrap-around: operand 16'hFFFF -> out=16'h0000, ovf=1; any other operand -> ovf=0.
REQ-026 Operand changes while req low have no effect; operand is sampled only at the granting edge.

Reset
REQ-027 rst_n low asynchronously forces state IDLE, gnt_a=0, gnt_b=0, valid=0, out=16'h0000, ovf=0, owner=0, pointer="B last".
REQ-028 Reset asserted mid-grant clears the grant immediately; the interrupted request is not completed and must be re-sampled after release.
REQ-029 First grant possible at the first rising edge after rst_n rises with a request present.

Verification
REQ-030 Single A: req_a=1, in_a=16'h0041 for one edge -> next cycle gnt_a=1, valid=1, out=16'h0042, owner=0, ovf=0.
REQ-031 Tie, FAIR=1: req_a=req_b=1 held, in_a=16'h0010, in_b=16'h0020 -> grants alternate A,B,A,B with out 16'h0011,16'h0021,16'h0011,16'h0021.
REQ-032 Tie, FAIR=0: same stimulus -> gnt_a every cycle, gnt_b never until req_a drops, then gnt_b the following cycle.
REQ-033 Wrap: req_b=1, in_b=16'hFFFF -> gnt_b=1, out=16'h0000, ovf=1, owner=1; next request in_b=16'h7FFF -> out=16'h8000, ovf=0.
REQ-034 Reset mid-operation: rst_n low during a gnt_a cycle -> gnt_a, valid, out, ovf drop to 0 without waiting for clk; after release with req_b=1 only, gnt_b one edge later.
REQ-035 Idle hold: after a grant with out=16'h1235, both req low for 5 cycles -> valid=0, out stays 16'h1235, no grant.
